exception_ctrl: RTL and testbench

- Exception/interrupt sequencer that sits directly downstream of the main decoder in the LEGv8 pipeline.
- Consumes the decoder's NotAnInstr and ERet flags, plus an external interrupt request.
- Decides when an exception is taken, captures ELR/ESR for MRS readback, and drives the PC-redirect and flush controls.
- Enforces a single handler level: a second fault inside a handler halts the core.

---
 rtl/exception_ctrl_pkg.sv | 24 ++
 rtl/exception_ctrl_if.sv | 33 +++
 rtl/sat_counter.sv | 24 ++
 rtl/exception_ctrl.sv | 122 ++++++++++++
 tb/tb_exception_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the LEGv8 exception sequencer.
// Holds the state encoding, the ESR syndrome codes and the default vector address.
package exception_ctrl_pkg;

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_TAKE    = 2'd1;
    localparam logic [1:0] S_HANDLER = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    typedef enum logic [1:0] {
        RUN     = S_RUN,
        TAKE    = S_TAKE,
        HANDLER = S_HANDLER,
        HALT    = S_HALT
    } state_t;

    localparam logic [3:0] ESR_IRQ     = 4'b0001;
    localparam logic [3:0] ESR_UNDEF   = 4'b0010;
    localparam logic [3:0] ESR_BADERET = 4'b0100;
    localparam logic [3:0] ESR_DFAULT  = 4'b1000;

    localparam logic [63:0] DEF_VECTOR_ADDR = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exception_ctrl_if.sv
// Decoder-to-exception-controller bundle: decode flags in, redirect/flush/syndrome out.
// The master side is the decode stage, the slave side is exception_ctrl.
interface exception_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             instr_valid;
    logic [63:0]      pc_d;
    logic             NotAnInstr;
    logic             ERet;
    logic             ExtIRQ;
    logic             ExtIAck;
    logic             Exc;
    logic [63:0]      exc_vector;
    logic             EretTaken;
    logic [63:0]      ELR;
    logic [3:0]       ESR;
    logic             in_handler;
    logic             Halted;
    logic [CNT_W-1:0] exc_count;

    modport master (
        output instr_valid, pc_d, NotAnInstr, ERet, ExtIRQ,
        input  ExtIAck, Exc, exc_vector, EretTaken, ELR, ESR,
               in_handler, Halted, exc_count
    );

    modport slave (
        input  instr_valid, pc_d, NotAnInstr, ERet, ExtIRQ,
        output ExtIAck, Exc, exc_vector, EretTaken, ELR, ESR,
               in_handler, Halted, exc_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous enable and asynchronous active-low clear.
// Latency: count visible the cycle after i_en; holds at all-ones; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer downstream of the decoder; single handler level.
// Latency: event in decode at N -> Exc/ExtIAck at N+1, in_handler from N+2.
// Backpressure: none; a fault inside the handler parks the core in HALT until reset.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [63:0] VECTOR_ADDR = DEF_VECTOR_ADDR,
    parameter int          CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    exception_ctrl_if.slave   bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_elr;
    logic [63:0] w_elr_nxt;
    logic [3:0]  r_esr;
    logic [3:0]  w_esr_nxt;
    logic        r_exc;
    logic        r_iack;
    logic        r_eret;
    logic        r_in_handler;
    logic        r_halted;
    logic        w_take;
    logic        w_iack_nxt;
    logic        w_eret_nxt;
    logic        w_undef;
    logic        w_eret_req;
    logic [CNT_W-1:0] w_cnt;

    // Decoder events only count for a real instruction; the IRQ line does not.
    assign w_undef    = bus.instr_valid & bus.NotAnInstr;
    assign w_eret_req = bus.instr_valid & bus.ERet;

    always_comb begin
        w_state_nxt = r_state;
        w_elr_nxt   = r_elr;
        w_esr_nxt   = r_esr;
        w_take      = 1'b0;
        w_iack_nxt  = 1'b0;
        w_eret_nxt  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_undef) begin
                    w_take    = 1'b1;
                    w_elr_nxt = bus.pc_d;
                    w_esr_nxt = ESR_UNDEF;
                end else if (w_eret_req) begin
                    w_take    = 1'b1;
                    w_elr_nxt = bus.pc_d;
                    w_esr_nxt = ESR_BADERET;
                end else if (bus.ExtIRQ) begin
                    w_take     = 1'b1;
                    w_iack_nxt = 1'b1;
                    w_elr_nxt  = bus.pc_d;
                    w_esr_nxt  = ESR_IRQ;
                end
            end
            // Decode is being flushed here, so its flags are not looked at.
            TAKE: w_state_nxt = HANDLER;
            HANDLER: begin
                if (w_eret_req) begin
                    w_state_nxt = RUN;
                    w_eret_nxt  = 1'b1;
                end else if (w_undef) begin
                    w_state_nxt = HALT;
                    w_esr_nxt   = ESR_DFAULT;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = RUN;
        endcase
        if (w_take) begin
            w_state_nxt = TAKE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RUN;
            r_elr        <= '0;
            r_esr        <= '0;
            r_exc        <= 1'b0;
            r_iack       <= 1'b0;
            r_eret       <= 1'b0;
            r_in_handler <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_elr        <= w_elr_nxt;
            r_esr        <= w_esr_nxt;
            r_exc        <= w_take;
            r_iack       <= w_iack_nxt;
            r_eret       <= w_eret_nxt;
            r_in_handler <= (w_state_nxt == HANDLER);
            r_halted     <= (w_state_nxt == HALT);
        end
    end

    // Counts on entry to TAKE so exc_count moves in the same cycle Exc shows.
    sat_counter #(
        .W(CNT_W)
    ) u_exc_cnt (
        .clk   (clk),
        .clr_n (reset),
        .i_en  (w_take),
        .o_cnt (w_cnt)
    );

    assign bus.Exc        = r_exc;
    assign bus.ExtIAck    = r_iack;
    assign bus.EretTaken  = r_eret;
    assign bus.ELR        = r_elr;
    assign bus.ESR        = r_esr;
    assign bus.in_handler = r_in_handler;
    assign bus.Halted     = r_halted;
    assign bus.exc_vector = VECTOR_ADDR;
    assign bus.exc_count  = w_cnt;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with an event-level reference model and per-cycle compare.
module tb_exception_ctrl;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    exception_ctrl_if #(.CNT_W(8)) bus ();

    exception_ctrl #(
        .VECTOR_ADDR (64'h0000_0000_0000_00D8),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks "an exception is being taken this cycle",
    // "a handler is running" and "the core is dead", plus captured link/syndrome.
    bit          m_take, m_iack, m_eret, m_inh, m_halt;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;
    int          m_cnt;

    function automatic void m_start(input logic [63:0] pc, input logic [3:0] code, input bit ack);
        m_take = 1;
        m_iack = ack;
        m_elr  = pc;
        m_esr  = code;
        if (m_cnt < 255) m_cnt++;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_take = 0; m_iack = 0; m_eret = 0; m_inh = 0; m_halt = 0;
            m_elr = '0; m_esr = '0; m_cnt = 0;
        end else if (m_halt) begin
            m_take = 0; m_iack = 0; m_eret = 0;
        end else if (m_take) begin
            m_take = 0; m_iack = 0; m_inh = 1;
        end else if (m_inh) begin
            m_eret = 0;
            if (bus.instr_valid && bus.ERet) begin
                m_inh = 0; m_eret = 1;
            end else if (bus.instr_valid && bus.NotAnInstr) begin
                m_inh = 0; m_halt = 1; m_esr = 4'd8;
            end
        end else begin
            m_eret = 0;
            if (bus.instr_valid && bus.NotAnInstr)      m_start(bus.pc_d, 4'd2, 0);
            else if (bus.instr_valid && bus.ERet)       m_start(bus.pc_d, 4'd4, 0);
            else if (bus.ExtIRQ)                        m_start(bus.pc_d, 4'd1, 1);
        end
    end

    always @(negedge clk) begin
        chk("cyc_Exc",        bus.Exc,        m_take);
        chk("cyc_ExtIAck",    bus.ExtIAck,    m_iack);
        chk("cyc_EretTaken",  bus.EretTaken,  m_eret);
        chk("cyc_in_handler", bus.in_handler, m_inh);
        chk("cyc_Halted",     bus.Halted,     m_halt);
        chk("cyc_ELR",        bus.ELR,        m_elr);
        chk("cyc_ESR",        bus.ESR,        m_esr);
        chk("cyc_exc_count",  bus.exc_count,  m_cnt[7:0]);
        chk("cyc_exc_vector", bus.exc_vector, 64'hD8);
    end

    always @(posedge clk) begin
        if (reset && bus.instr_valid && bus.ERet && bus.NotAnInstr) begin
            bad++;
            $display("FAIL decoder_excl: ERet and NotAnInstr both set (t=%0t)", $time);
        end
    end

    task automatic drive(input bit v, input logic [63:0] pc, input bit nai, input bit er, input bit irq);
        bus.instr_valid = v;
        bus.pc_d        = pc;
        bus.NotAnInstr  = nai;
        bus.ERet        = er;
        bus.ExtIRQ      = irq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 64'h100, 0, 0, 1);
        #1 reset = 1'b0;

        // Reset held with IRQ pending: nothing happens.
        repeat (3) tick();
        chk("rst_Exc",     bus.Exc,       1'b0);
        chk("rst_ExtIAck", bus.ExtIAck,   1'b0);
        chk("rst_ESR",     bus.ESR,       4'd0);
        chk("rst_ELR",     bus.ELR,       64'd0);
        chk("rst_count",   bus.exc_count, 8'd0);
        reset = 1'b1;
        tick();
        chk("irq_Exc",   bus.Exc,       1'b1);
        chk("irq_ack",   bus.ExtIAck,   1'b1);
        chk("irq_ESR",   bus.ESR,       4'd1);
        chk("irq_ELR",   bus.ELR,       64'h100);
        chk("irq_count", bus.exc_count, 8'd1);
        drive(0, 64'h104, 0, 0, 0);
        tick();
        chk("irq_inh",   bus.in_handler, 1'b1);
        chk("irq_ack_1", bus.ExtIAck,    1'b0);
        drive(1, 64'h200, 0, 1, 0);
        tick();
        chk("irq_eret",     bus.EretTaken,  1'b1);
        chk("irq_inh_out",  bus.in_handler, 1'b0);
        chk("irq_ELR_hold", bus.ELR,        64'h100);
        drive(0, 64'h204, 0, 0, 0);
        tick();

        // Undefined opcode.
        drive(1, 64'h40, 1, 0, 0);
        tick();
        chk("und_Exc", bus.Exc, 1'b1);
        chk("und_ELR", bus.ELR, 64'h40);
        chk("und_ESR", bus.ESR, 4'd2);
        drive(0, 64'h44, 0, 0, 0);
        tick();
        chk("und_inh", bus.in_handler, 1'b1);
        drive(1, 64'h48, 0, 1, 0);
        tick();
        chk("und_eret", bus.EretTaken, 1'b1);
        drive(0, 64'h4C, 0, 0, 0);
        tick();

        // Fault and IRQ together: fault wins, IRQ stays pending and masked.
        drive(1, 64'h10, 1, 0, 1);
        tick();
        chk("sim_ESR", bus.ESR,     4'd2);
        chk("sim_ack", bus.ExtIAck, 1'b0);
        chk("sim_ELR", bus.ELR,     64'h10);
        drive(0, 64'h14, 0, 0, 1);
        repeat (4) tick();
        chk("mask_Exc", bus.Exc,        1'b0);
        chk("mask_inh", bus.in_handler, 1'b1);
        drive(1, 64'h20, 0, 1, 1);
        tick();
        chk("sim_eret", bus.EretTaken, 1'b1);
        drive(0, 64'h14, 0, 0, 1);
        tick();
        chk("b2b_Exc",   bus.Exc,       1'b1);
        chk("b2b_ack",   bus.ExtIAck,   1'b1);
        chk("b2b_ESR",   bus.ESR,       4'd1);
        chk("b2b_ELR",   bus.ELR,       64'h14);
        chk("b2b_count", bus.exc_count, 8'd4);
        drive(0, 64'h18, 0, 0, 0);
        tick();
        drive(1, 64'h1C, 0, 1, 0);
        tick();
        drive(0, 64'h1C, 0, 0, 0);
        tick();

        // Bubble carrying a stale NotAnInstr.
        drive(0, 64'h30, 1, 0, 0);
        repeat (3) tick();
        chk("bub_Exc",   bus.Exc,        1'b0);
        chk("bub_inh",   bus.in_handler, 1'b0);
        chk("bub_count", bus.exc_count,  8'd4);

        // Double fault, then ERet pulses must not revive the core.
        drive(1, 64'h80, 1, 0, 0);
        tick();
        drive(0, 64'h84, 0, 0, 0);
        tick();
        drive(1, 64'h84, 1, 0, 0);
        tick();
        chk("df_Halted", bus.Halted,     1'b1);
        chk("df_ESR",    bus.ESR,        4'd8);
        chk("df_ELR",    bus.ELR,        64'h80);
        chk("df_inh",    bus.in_handler, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(i % 2 == 0, 64'h90, 0, i % 2 == 0, 0);
            tick();
        end
        chk("halt_Halted", bus.Halted,    1'b1);
        chk("halt_eret",   bus.EretTaken, 1'b0);
        chk("halt_Exc",    bus.Exc,       1'b0);
        chk("halt_count",  bus.exc_count, 8'd5);
        drive(0, 64'h0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("hrst_Halted", bus.Halted,    1'b0);
        chk("hrst_ESR",    bus.ESR,       4'd0);
        chk("hrst_count",  bus.exc_count, 8'd0);
        tick();
        reset = 1'b1;
        tick();

        // ERet with no handler, repeated until the counter saturates.
        drive(1, 64'h300, 0, 1, 0);
        tick();
        chk("bad_eret_Exc", bus.Exc, 1'b1);
        chk("bad_eret_ESR", bus.ESR, 4'd4);
        chk("bad_eret_ELR", bus.ELR, 64'h300);
        repeat (899) tick();
        drive(0, 64'h0, 0, 0, 0);
        chk("sat_count", bus.exc_count, 8'd255);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
